cv32e40p_sleep_ctrl: RTL

- Drives the enable of the core clock gate. Decides cycle by cycle whether the gated core clock runs.
- Sleeps the core only after a WFI request has drained all outstanding bus transactions. Wakes it on a pending interrupt or debug request.
- Runs on the free-running clock, upstream of the gate's en_i; scan override stays inside the gate cell.

---
 rtl/cv32e40p_sleep_ctrl.sv | 73 +++++++
 1 files changed

// File: rtl/cv32e40p_sleep_ctrl.sv
// cv32e40p_sleep_ctrl: gates the core clock after a drained WFI and reopens it on interrupt or debug request.
module cv32e40p_sleep_ctrl #(
    parameter  int MAX_OUTSTANDING = 2,
    parameter  int WAKE_CYCLES     = 2,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_enable_i,
    input  logic             wfi_req_i,
    input  logic             irq_pending_i,
    input  logic             debug_req_i,
    input  logic             bus_req_i,
    input  logic             bus_gnt_i,
    input  logic             bus_rvalid_i,
    output logic             clk_en_o,
    output logic             core_sleep_o,
    output logic             wake_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_o
);
    typedef enum logic [2:0] {BOOT, RUN, DRAIN, SLEEP, WAKE} state_t;
    state_t state, state_nx;
    logic [3:0] wcnt;
    logic wake_cond, issue, inc, dec;
    assign wake_cond = irq_pending_i | debug_req_i;
    assign issue     = bus_req_i & bus_gnt_i;
    assign inc       = issue & ~bus_rvalid_i;
    assign dec       = bus_rvalid_i & ~issue;
    always_comb begin
        state_nx = state;
        case (state)
            BOOT:    state_nx = fetch_enable_i ? RUN : BOOT;
            RUN:     state_nx = (wfi_req_i && !wake_cond) ? DRAIN : RUN;
            DRAIN:   state_nx = wake_cond ? RUN : (outstanding_o == '0 && !issue) ? SLEEP : DRAIN;
            SLEEP:   state_nx = wake_cond ? WAKE : SLEEP;
            WAKE:    state_nx = (wcnt == 4'd0) ? RUN : WAKE;
            default: state_nx = BOOT;
        endcase
    end
    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= BOOT;
            clk_en_o      <= 1'b0;
            core_sleep_o  <= 1'b0;
            wake_o        <= 1'b0;
            outstanding_o <= '0;
            err_o         <= 1'b0;
            wcnt          <= 4'd0;
        end else begin
            state        <= state_nx;
            clk_en_o     <= state_nx inside {RUN, DRAIN, WAKE};
            core_sleep_o <= state_nx inside {SLEEP, WAKE};
            wake_o       <= state == WAKE && state_nx == RUN;
            wcnt         <= (state_nx == WAKE && state != WAKE) ? 4'(WAKE_CYCLES - 1) :
                            (wcnt != 4'd0) ? wcnt - 4'd1 : wcnt;
            if (state == BOOT) begin
                outstanding_o <= '0;
            end else begin
                if (inc) begin
                    if (outstanding_o == CNT_W'(MAX_OUTSTANDING)) err_o <= 1'b1;
                    else outstanding_o <= outstanding_o + 1'b1;
                end
                if (dec) begin
                    if (outstanding_o == '0) err_o <= 1'b1;
                    else outstanding_o <= outstanding_o - 1'b1;
                end
                if (state == SLEEP && (issue || bus_rvalid_i)) err_o <= 1'b1;
            end
        end
    end
endmodule
